axil_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares one AXI-lite write channel (AW/W/B) among S_COUNT requesting masters.
- Sits in front of a single AXI-lite write slave, typically a width adapter or register bank.
- Holds one transaction at a time: grant → AW+W forwarded → B routed back → release.
- Uses flattened vector ports, one slice per requester.

---
 rtl/axil_wr_arbiter_if.sv | 62 ++++++
 rtl/axil_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_axil_wr_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_wr_arbiter_if.sv
// rtl/axil_wr_arbiter_if.sv - shared AXI-lite write bus bundle: S_COUNT requester slices plus one downstream master port
interface axil_wr_arbiter_if #(
    parameter int S_COUNT    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_awaddr;
    logic [S_COUNT*3-1:0]          s_axil_awprot;
    logic [S_COUNT-1:0]            s_axil_awvalid;
    logic [S_COUNT-1:0]            s_axil_awready;
    logic [S_COUNT*DATA_WIDTH-1:0] s_axil_wdata;
    logic [S_COUNT*STRB_WIDTH-1:0] s_axil_wstrb;
    logic [S_COUNT-1:0]            s_axil_wvalid;
    logic [S_COUNT-1:0]            s_axil_wready;
    logic [S_COUNT*2-1:0]          s_axil_bresp;
    logic [S_COUNT-1:0]            s_axil_bvalid;
    logic [S_COUNT-1:0]            s_axil_bready;

    logic [ADDR_WIDTH-1:0]         m_axil_awaddr;
    logic [2:0]                    m_axil_awprot;
    logic                          m_axil_awvalid;
    logic                          m_axil_awready;
    logic [DATA_WIDTH-1:0]         m_axil_wdata;
    logic [STRB_WIDTH-1:0]         m_axil_wstrb;
    logic                          m_axil_wvalid;
    logic                          m_axil_wready;
    logic [1:0]                    m_axil_bresp;
    logic                          m_axil_bvalid;
    logic                          m_axil_bready;

    // The arbiter's view: requester slices in, shared master port out.
    modport slave (
        input  s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
        output s_axil_awready,
        input  s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        output s_axil_wready,
        output s_axil_bresp, s_axil_bvalid,
        input  s_axil_bready,
        output m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
        input  m_axil_awready,
        output m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
        input  m_axil_wready,
        input  m_axil_bresp, m_axil_bvalid,
        output m_axil_bready
    );

    modport master (
        output s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
        input  s_axil_awready,
        output s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        input  s_axil_wready,
        input  s_axil_bresp, s_axil_bvalid,
        output s_axil_bready,
        input  m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
        output m_axil_awready,
        input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
        output m_axil_wready,
        output m_axil_bresp, m_axil_bvalid,
        input  m_axil_bready
    );
endinterface

// File: rtl/axil_wr_arbiter.sv
// rtl/axil_wr_arbiter.sv - one-transaction-at-a-time AXI-lite write arbiter, round-robin by default
// AXIL_WR_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead of round-robin.
module axil_wr_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int SEL_WIDTH  = $clog2(S_COUNT)
) (
    input  logic                clk,
    input  logic                rst,
    axil_wr_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t               state_q, state_d;
    logic [SEL_WIDTH-1:0] grant_q, grant_d;
    logic                 aw_done_q, aw_done_d;
    logic                 wr_done_q, wr_done_d;
    logic                 pick_valid;
    logic [SEL_WIDTH-1:0] pick_idx;
    logic [SEL_WIDTH-1:0] cand;
    logic                 aw_hs, w_hs, b_hs;
`ifndef AXIL_WR_ARB_FIXED_PRIO_EN
    logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
`endif

    // Scan downwards so the lowest offset from the search start wins without a break.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
`ifdef AXIL_WR_ARB_FIXED_PRIO_EN
            cand = SEL_WIDTH'(i);
`else
            cand = SEL_WIDTH'((int'(rr_ptr_q) + i) % S_COUNT);
`endif
            if (bus.s_axil_awvalid[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        aw_done_d = aw_done_q;
        wr_done_d = wr_done_q;
`ifndef AXIL_WR_ARB_FIXED_PRIO_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        aw_hs = 1'b0;
        w_hs  = 1'b0;
        b_hs  = 1'b0;

        bus.s_axil_awready = '0;
        bus.s_axil_wready  = '0;
        bus.s_axil_bvalid  = '0;
        bus.s_axil_bresp   = '0;
        bus.m_axil_awaddr  = '0;
        bus.m_axil_awprot  = '0;
        bus.m_axil_awvalid = 1'b0;
        bus.m_axil_wdata   = '0;
        bus.m_axil_wstrb   = '0;
        bus.m_axil_wvalid  = 1'b0;
        bus.m_axil_bready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                bus.m_axil_awaddr  = bus.s_axil_awaddr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
                bus.m_axil_awprot  = bus.s_axil_awprot[grant_q*3 +: 3];
                bus.m_axil_awvalid = bus.s_axil_awvalid[grant_q] & ~aw_done_q;
                bus.s_axil_awready[grant_q] = bus.m_axil_awready & ~aw_done_q;
                bus.m_axil_wdata   = bus.s_axil_wdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
                bus.m_axil_wstrb   = bus.s_axil_wstrb[grant_q*STRB_WIDTH +: STRB_WIDTH];
                bus.m_axil_wvalid  = bus.s_axil_wvalid[grant_q] & ~wr_done_q;
                bus.s_axil_wready[grant_q] = bus.m_axil_wready & ~wr_done_q;

                aw_hs = bus.s_axil_awvalid[grant_q] & bus.m_axil_awready & ~aw_done_q;
                w_hs  = bus.s_axil_wvalid[grant_q] & bus.m_axil_wready & ~wr_done_q;
                aw_done_d = aw_done_q | aw_hs;
                wr_done_d = wr_done_q | w_hs;
                if (aw_done_d && wr_done_d) begin
                    aw_done_d = 1'b0;
                    wr_done_d = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                bus.m_axil_bready = bus.s_axil_bready[grant_q];
                bus.s_axil_bvalid[grant_q] = bus.m_axil_bvalid;
                bus.s_axil_bresp[grant_q*2 +: 2] = bus.m_axil_bresp;
                b_hs = bus.m_axil_bvalid & bus.s_axil_bready[grant_q];
                if (b_hs) begin
`ifndef AXIL_WR_ARB_FIXED_PRIO_EN
                    rr_ptr_d = (int'(grant_q) == S_COUNT - 1) ? '0 : grant_q + 1'b1;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            aw_done_q <= 1'b0;
            wr_done_q <= 1'b0;
`ifndef AXIL_WR_ARB_FIXED_PRIO_EN
            rr_ptr_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            aw_done_q <= aw_done_d;
            wr_done_q <= wr_done_d;
`ifndef AXIL_WR_ARB_FIXED_PRIO_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end

    // Only the granted slice may ever be driven.
    a_awready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.s_axil_awready));
    a_wready_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(bus.s_axil_wready));
    a_bvalid_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(bus.s_axil_bvalid));
endmodule

// File: tb/tb_axil_wr_arbiter.sv
// tb/tb_axil_wr_arbiter.sv - directed self-checking bench for axil_wr_arbiter
module tb_axil_wr_arbiter;
    localparam int S  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_wr_arbiter_if #(.S_COUNT(S), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

    axil_wr_arbiter #(.S_COUNT(S), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int aw_cnt   = 0;
    int w_cnt    = 0;
    int b_cnt    = 0;
    int a0, w0;
    int g;
    int cnt [S];
    int exp_order [9];

    always @(posedge clk) begin
        if (bus.m_axil_awvalid && bus.m_axil_awready) aw_cnt++;
        if (bus.m_axil_wvalid && bus.m_axil_wready) w_cnt++;
        if (bus.m_axil_bvalid && bus.m_axil_bready) b_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int onehot_idx(input logic [S-1:0] v);
        int r = -1;
        for (int i = 0; i < S; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Waits for a forwarded AW, completes AW/W with an always-ready slave, returns OKAY.
    task automatic serve(output int gi);
        gi = -1;
        for (int k = 0; k < 20 && gi < 0; k++) begin
            @(negedge clk);
            if (bus.m_axil_awvalid) gi = onehot_idx(bus.s_axil_awready);
        end
        chk("serve_grant_seen", 64'(gi >= 0), 64'd1);
        if (gi >= 0) begin
            @(posedge clk); #1;
            bus.m_axil_bvalid = 1'b1;
            bus.m_axil_bresp  = 2'b00;
            @(negedge clk);
            chk("serve_bvalid", bus.s_axil_bvalid, 64'(1 << gi));
            @(posedge clk); #1;
            bus.m_axil_bvalid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_axil_awaddr  = '0;
        bus.s_axil_awprot  = '0;
        bus.s_axil_awvalid = '0;
        bus.s_axil_wdata   = '0;
        bus.s_axil_wstrb   = '0;
        bus.s_axil_wvalid  = '0;
        bus.s_axil_bready  = '0;
        bus.m_axil_awready = 1'b0;
        bus.m_axil_wready  = 1'b0;
        bus.m_axil_bresp   = 2'b00;
        bus.m_axil_bvalid  = 1'b0;

        #2;
        chk("rst_s_awready", bus.s_axil_awready, 0);
        chk("rst_s_wready",  bus.s_axil_wready,  0);
        chk("rst_s_bvalid",  bus.s_axil_bvalid,  0);
        chk("rst_m_awvalid", bus.m_axil_awvalid, 0);
        chk("rst_m_wvalid",  bus.m_axil_wvalid,  0);
        chk("rst_m_bready",  bus.m_axil_bready,  0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Round-robin: requesters 0,1,3 each post three writes back to back.
`ifdef AXIL_WR_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 1, 1, 1, 3, 3, 3};
`else
        exp_order = '{0, 1, 3, 0, 1, 3, 0, 1, 3};
`endif
        cnt = '{3, 3, 0, 3};
        bus.s_axil_awvalid = 4'b1011;
        bus.s_axil_wvalid  = 4'b1011;
        bus.s_axil_bready  = 4'b1111;
        bus.m_axil_awready = 1'b1;
        bus.m_axil_wready  = 1'b1;
        for (int k = 0; k < 9; k++) begin
            serve(g);
            chk($sformatf("rr_grant_%0d", k), 64'(g), 64'(exp_order[k]));
            if (g >= 0) begin
                cnt[g]--;
                if (cnt[g] == 0) begin
                    bus.s_axil_awvalid[g] = 1'b0;
                    bus.s_axil_wvalid[g]  = 1'b0;
                end
            end
        end
        chk("rr_aw_count", aw_cnt, 9);
        chk("rr_w_count",  w_cnt,  9);
        chk("rr_b_count",  b_cnt,  9);

        // Single request from requester 2.
        bus.s_axil_awaddr[2*AW +: AW] = 32'h0000_0100;
        bus.s_axil_wdata[2*DW +: DW]  = 32'hDEAD_BEEF;
        bus.s_axil_wstrb[2*SW +: SW]  = 4'hF;
        bus.s_axil_awvalid = 4'b0100;
        bus.s_axil_wvalid  = 4'b0100;
        @(negedge clk);
        chk("single_arb_m_awvalid", bus.m_axil_awvalid, 0);
        chk("single_arb_s_awready", bus.s_axil_awready, 0);
        @(negedge clk);
        chk("single_m_awvalid", bus.m_axil_awvalid, 1);
        chk("single_m_awaddr",  bus.m_axil_awaddr,  32'h100);
        chk("single_m_wdata",   bus.m_axil_wdata,   32'hDEADBEEF);
        chk("single_m_wstrb",   bus.m_axil_wstrb,   4'hF);
        chk("single_s_awready", bus.s_axil_awready, 4'b0100);
        chk("single_s_wready",  bus.s_axil_wready,  4'b0100);
        @(posedge clk); #1;
        bus.s_axil_awvalid = '0;
        bus.s_axil_wvalid  = '0;
        bus.m_axil_bvalid  = 1'b1;
        bus.m_axil_bresp   = 2'b00;
        @(negedge clk);
        chk("single_s_bvalid", bus.s_axil_bvalid, 4'b0100);
        chk("single_s_bresp",  bus.s_axil_bresp,  8'h00);
        chk("single_m_bready", bus.m_axil_bready, 1);
        @(posedge clk); #1;
        bus.m_axil_bvalid = 1'b0;
        @(negedge clk);
        chk("single_idle_m_awvalid", bus.m_axil_awvalid, 0);
        chk("single_idle_s_bvalid",  bus.s_axil_bvalid,  0);

        // W before AW from requester 1, AW held off by the slave for two cycles.
        @(posedge clk); #1;
        a0 = aw_cnt;
        w0 = w_cnt;
        bus.m_axil_awready = 1'b0;
        bus.m_axil_wready  = 1'b1;
        bus.s_axil_wdata[1*DW +: DW] = 32'h1111_2222;
        bus.s_axil_wstrb[1*SW +: SW] = 4'hF;
        bus.s_axil_wvalid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("wfirst_m_wvalid_%0d", k), bus.m_axil_wvalid, 0);
            chk($sformatf("wfirst_s_wready_%0d", k), bus.s_axil_wready, 0);
        end
        @(posedge clk); #1;
        bus.s_axil_awaddr[1*AW +: AW] = 32'h0000_0200;
        bus.s_axil_awvalid = 4'b0010;
        @(negedge clk);
        chk("wfirst_arb_m_awvalid", bus.m_axil_awvalid, 0);
        @(negedge clk);
        chk("wfirst_m_wvalid",  bus.m_axil_wvalid,  1);
        chk("wfirst_s_wready",  bus.s_axil_wready,  4'b0010);
        chk("wfirst_m_awvalid", bus.m_axil_awvalid, 1);
        chk("wfirst_s_awready", bus.s_axil_awready, 0);
        @(posedge clk); #1;
        bus.s_axil_wvalid = '0;
        @(negedge clk);
        chk("wfirst_wdone_m_wvalid", bus.m_axil_wvalid, 0);
        chk("wfirst_w_once",   w_cnt - w0,  1);
        chk("wfirst_aw_none",  aw_cnt - a0, 0);
        chk("wfirst_aw_still", bus.m_axil_awvalid, 1);
        @(posedge clk); #1;
        bus.m_axil_awready = 1'b1;
        @(negedge clk);
        chk("wfirst_s_awready_late", bus.s_axil_awready, 4'b0010);
        @(posedge clk); #1;
        bus.s_axil_awvalid = '0;
        bus.m_axil_bvalid  = 1'b1;
        @(negedge clk);
        chk("wfirst_s_bvalid", bus.s_axil_bvalid, 4'b0010);
        @(posedge clk); #1;
        bus.m_axil_bvalid = 1'b0;
        @(negedge clk);
        chk("wfirst_aw_once", aw_cnt - a0, 1);
        chk("wfirst_w_total", w_cnt - w0,  1);

        // SLVERR with B backpressure on requester 0; requester 3 waits behind it.
        @(posedge clk); #1;
        bus.s_axil_awaddr[0 +: AW] = 32'h0000_0300;
        bus.s_axil_awvalid = 4'b0001;
        bus.s_axil_wvalid  = 4'b0001;
        bus.s_axil_bready  = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("err_s_awready", bus.s_axil_awready, 4'b0001);
        @(posedge clk); #1;
        bus.s_axil_awvalid = 4'b1000;
        bus.s_axil_wvalid  = 4'b1000;
        bus.m_axil_bvalid  = 1'b1;
        bus.m_axil_bresp   = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("err_m_bready_%0d", k), bus.m_axil_bready, 0);
            chk($sformatf("err_s_bresp_%0d", k),  bus.s_axil_bresp[1:0], 2'b10);
            chk($sformatf("err_s_bvalid_%0d", k), bus.s_axil_bvalid, 4'b0001);
        end
        @(posedge clk); #1;
        bus.s_axil_bready = 4'b0001;
        @(negedge clk);
        chk("err_m_bready_go", bus.m_axil_bready, 1);
        @(posedge clk); #1;
        bus.m_axil_bvalid = 1'b0;
        bus.m_axil_bresp  = 2'b00;
        bus.s_axil_bready = 4'b1111;
        @(negedge clk);
        chk("err_idle_m_awvalid", bus.m_axil_awvalid, 0);
        @(negedge clk);
        chk("err_next_m_awvalid", bus.m_axil_awvalid, 1);
        chk("err_next_s_awready", bus.s_axil_awready, 4'b1000);
        @(posedge clk); #1;
        bus.s_axil_awvalid = '0;
        bus.s_axil_wvalid  = '0;
        bus.m_axil_bvalid  = 1'b1;
        @(negedge clk);
        chk("err_next_s_bvalid", bus.s_axil_bvalid, 4'b1000);
        @(posedge clk); #1;
        bus.m_axil_bvalid = 1'b0;

        // Reset asserted mid-XFER on requester 2.
        bus.m_axil_awready = 1'b0;
        bus.m_axil_wready  = 1'b0;
        bus.s_axil_awvalid = 4'b0100;
        bus.s_axil_wvalid  = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        chk("rstx_m_awvalid_before", bus.m_axil_awvalid, 1);
        #1;
        bus.m_axil_awready = 1'b1;
        bus.m_axil_wready  = 1'b1;
        #1;
        chk("rstx_s_awready_before", bus.s_axil_awready, 4'b0100);
        chk("rstx_s_wready_before",  bus.s_axil_wready,  4'b0100);
        rst = 1'b1;
        #1;
        chk("rstx_m_awvalid", bus.m_axil_awvalid, 0);
        chk("rstx_m_wvalid",  bus.m_axil_wvalid,  0);
        chk("rstx_s_awready", bus.s_axil_awready, 0);
        chk("rstx_s_wready",  bus.s_axil_wready,  0);
        bus.s_axil_awvalid = '0;
        bus.s_axil_wvalid  = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.s_axil_awvalid = 4'b1000;
        bus.s_axil_wvalid  = 4'b1000;
        @(negedge clk);
        chk("rstx_arb_m_awvalid", bus.m_axil_awvalid, 0);
        @(negedge clk);
        chk("rstx_next_s_awready", bus.s_axil_awready, 4'b1000);
        @(posedge clk); #1;
        bus.s_axil_awvalid = '0;
        bus.s_axil_wvalid  = '0;
        bus.m_axil_bvalid  = 1'b1;
        @(negedge clk);
        chk("rstx_next_s_bvalid", bus.s_axil_bvalid, 4'b1000);
        @(posedge clk); #1;
        bus.m_axil_bvalid = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
